// File: rtl/alu_pkg.sv
// Shared types for the pipelined integer ALU: op encodings, operand-2 select
// and the per-stage payload carried down the pipe.
package alu_pkg;

    localparam int ALU_XLEN   = 32;
    localparam int ALU_PREG_W = 7;
    localparam int ALU_TAG_W  = 5;
    localparam int ALU_ADDR_W = 32;
    localparam int ALU_OP_W   = 5;

    // Codes 16..31 are undefined: they flow through the pipe with a zero result.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9,
        ALU_BEQ  = 5'd10,
        ALU_BNE  = 5'd11,
        ALU_BLT  = 5'd12,
        ALU_BGE  = 5'd13,
        ALU_BLTU = 5'd14,
        ALU_BGEU = 5'd15
    } alu_op_t;

    typedef enum logic {
        ALU_SRC_REG = 1'b0,
        ALU_SRC_IMM = 1'b1
    } alu_src_t;

    typedef struct packed {
        logic [ALU_XLEN-1:0]   result;
        logic [ALU_PREG_W-1:0] addr;
        logic [ALU_TAG_W-1:0]  tag;
        logic                  taken;
        logic [ALU_ADDR_W-1:0] target;
        logic                  valid;
    } stage_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational op/branch evaluator feeding stage 1 of alu_pipe.
// Branches always compare the two register operands; result is 0 for them.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    input  logic [XLEN-1:0]     imm,
    input  logic                alu_src,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic                is_branch,
    input  logic [ADDR_W-1:0]   pc,
    output logic [XLEN-1:0]     result,
    output logic                taken,
    output logic [ADDR_W-1:0]   target
);

    localparam int SHW = $clog2(XLEN);

    alu_op_t         op;
    logic [XLEN-1:0] op2;
    logic [SHW-1:0]  shamt;
    logic            br_op;
    logic            cond;

    assign op    = alu_op_t'(alu_op);
    assign op2   = (alu_src_t'(alu_src) == ALU_SRC_IMM) ? imm : src2;
    assign shamt = op2[SHW-1:0];

    always_comb begin
        result = '0;
        br_op  = 1'b0;
        cond   = 1'b0;
        case (op)
            ALU_ADD:  result = src1 + op2;
            ALU_SUB:  result = src1 - op2;
            ALU_AND:  result = src1 & op2;
            ALU_OR:   result = src1 | op2;
            ALU_XOR:  result = src1 ^ op2;
            ALU_SLL:  result = src1 << shamt;
            ALU_SRL:  result = src1 >> shamt;
            ALU_SRA:  result = XLEN'($signed(src1) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(op2))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (src1 < op2)};
            ALU_BEQ:  begin br_op = 1'b1; cond = (src1 == src2); end
            ALU_BNE:  begin br_op = 1'b1; cond = (src1 != src2); end
            ALU_BLT:  begin br_op = 1'b1; cond = ($signed(src1) <  $signed(src2)); end
            ALU_BGE:  begin br_op = 1'b1; cond = ($signed(src1) >= $signed(src2)); end
            ALU_BLTU: begin br_op = 1'b1; cond = (src1 <  src2); end
            ALU_BGEU: begin br_op = 1'b1; cond = (src1 >= src2); end
            default:  result = '0;
        endcase
        // A branch encoding without is_branch is a no-op, not a branch.
        taken  = is_branch && br_op && cond;
        target = '0;
        if (is_branch && br_op) begin
            target = taken ? (pc + imm[ADDR_W-1:0]) : (pc + ADDR_W'(4));
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Fully pipelined ALU with global-stall valid/ready backpressure, mispredict
// flush and an occupancy count of valid stages.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int PREG_W  = ALU_PREG_W,
    parameter int TAG_W   = ALU_TAG_W,
    parameter int ADDR_W  = ALU_ADDR_W,
    parameter int LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [XLEN-1:0]                src1_val,
    input  logic [XLEN-1:0]                src2_val,
    input  logic [XLEN-1:0]                imm,
    input  logic                           alu_src,
    input  logic [ALU_OP_W-1:0]            alu_op,
    input  logic                           is_branch,
    input  logic [ADDR_W-1:0]              pc_in,
    input  logic [PREG_W-1:0]              dst_reg_addr,
    input  logic [TAG_W-1:0]               tag_in,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [XLEN-1:0]                result_val,
    output logic [PREG_W-1:0]              result_addr,
    output logic [TAG_W-1:0]               tag_out,
    output logic                           branch_taken,
    output logic [ADDR_W-1:0]              branch_target,
    output logic [$clog2(LATENCY+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(LATENCY+1);

    logic [XLEN-1:0]   core_result;
    logic              core_taken;
    logic [ADDR_W-1:0] core_target;
    logic              advance;

    stage_t stage_q [1:LATENCY];
    stage_t stage_d [1:LATENCY];

    alu_core #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_core (
        .src1      (src1_val),
        .src2      (src2_val),
        .imm       (imm),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .is_branch (is_branch),
        .pc        (pc_in),
        .result    (core_result),
        .taken     (core_taken),
        .target    (core_target)
    );

    assign advance  = !stage_q[LATENCY].valid || out_ready;
    assign in_ready = advance && !flush;

    // Payload of a stage that receives a bubble keeps its old contents.
    always_comb begin
        for (int k = 1; k <= LATENCY; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (flush) begin
            for (int k = 1; k <= LATENCY; k++) begin
                stage_d[k].valid = 1'b0;
            end
        end else if (advance) begin
            stage_d[1].valid = in_valid;
            if (in_valid) begin
                stage_d[1].result = core_result;
                stage_d[1].addr   = dst_reg_addr;
                stage_d[1].tag    = tag_in;
                stage_d[1].taken  = core_taken;
                stage_d[1].target = core_target;
            end
            for (int k = 2; k <= LATENCY; k++) begin
                stage_d[k].valid = stage_q[k-1].valid;
                if (stage_q[k-1].valid) begin
                    stage_d[k] = stage_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= LATENCY; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= LATENCY; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid     = stage_q[LATENCY].valid && !flush;
    assign result_val    = out_valid ? stage_q[LATENCY].result : '0;
    assign result_addr   = out_valid ? stage_q[LATENCY].addr   : '0;
    assign tag_out       = out_valid ? stage_q[LATENCY].tag    : '0;
    assign branch_taken  = out_valid ? stage_q[LATENCY].taken  : 1'b0;
    assign branch_target = out_valid ? stage_q[LATENCY].target : '0;

    always_comb begin
        occupancy = '0;
        for (int k = 1; k <= LATENCY; k++) begin
            if (stage_q[k].valid) begin
                occupancy = occupancy + OCC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected results are queued on accept and
// compared, with their latency, when the pipe hands them to the CDB.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int LAT = 2;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1_val;
    logic [31:0] src2_val;
    logic [31:0] imm;
    logic        alu_src;
    logic [4:0]  alu_op;
    logic        is_branch;
    logic [31:0] pc_in;
    logic [6:0]  dst_reg_addr;
    logic [4:0]  tag_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_val;
    logic [6:0]  result_addr;
    logic [4:0]  tag_out;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [1:0]  occupancy;

    alu_pipe #(.LATENCY(LAT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .src1_val      (src1_val),
        .src2_val      (src2_val),
        .imm           (imm),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .is_branch     (is_branch),
        .pc_in         (pc_in),
        .dst_reg_addr  (dst_reg_addr),
        .tag_in        (tag_in),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result_val    (result_val),
        .result_addr   (result_addr),
        .tag_out       (tag_out),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .occupancy     (occupancy)
    );

    typedef struct {
        logic [31:0] res;
        logic [6:0]  addr;
        logic [4:0]  tag;
        logic        taken;
        logic [31:0] tgt;
        int          acc_cyc;
        int          acc_st;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   stalls = 0;
    int   n_out = 0;
    bit   rnd_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] im, input logic src, input logic isbr,
                                   input logic [31:0] pc, input logic [6:0] dst, input logic [4:0] tg);
        exp_t        e;
        logic [31:0] o2;
        logic [4:0]  sh;
        logic        br;
        logic        c;
        o2 = src ? im : b;
        sh = o2[4:0];
        br = 1'b0;
        c  = 1'b0;
        e.res = 32'h0;
        case (op)
            ALU_ADD:  e.res = a + o2;
            ALU_SUB:  e.res = a + ~o2 + 32'd1;
            ALU_AND:  e.res = a & o2;
            ALU_OR:   e.res = a | o2;
            ALU_XOR:  e.res = a ^ o2;
            ALU_SLL:  e.res = a << sh;
            ALU_SRL:  e.res = a >> sh;
            ALU_SRA:  begin
                e.res = a >> sh;
                if (a[31]) e.res = e.res | ~(32'hFFFF_FFFF >> sh);
            end
            ALU_SLT:  e.res = (a[31] != o2[31]) ? {31'd0, a[31]} : {31'd0, a < o2};
            ALU_SLTU: e.res = {31'd0, a < o2};
            ALU_BEQ:  begin br = 1'b1; c = (a == b); end
            ALU_BNE:  begin br = 1'b1; c = (a != b); end
            ALU_BLT:  begin br = 1'b1; c = (a[31] != b[31]) ? a[31] : (a < b); end
            ALU_BGE:  begin br = 1'b1; c = !((a[31] != b[31]) ? a[31] : (a < b)); end
            ALU_BLTU: begin br = 1'b1; c = (a < b); end
            ALU_BGEU: begin br = 1'b1; c = !(a < b); end
            default:  e.res = 32'h0;
        endcase
        e.taken   = isbr && br && c;
        e.tgt     = (isbr && br) ? (c ? pc + im : pc + 32'd4) : 32'h0;
        e.addr    = dst;
        e.tag     = tg;
        e.acc_cyc = 0;
        e.acc_st  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            sb.delete();
        end else begin
            check_eq("occupancy", 64'(occupancy), 64'(sb.size()));
            if (!out_valid) begin
                check_eq("idle_outputs_zero",
                         64'(|{result_val, result_addr, tag_out, branch_taken, branch_target}), 64'd0);
            end
            if (flush) begin
                check_eq("flush_out_valid", 64'(out_valid), 64'd0);
                check_eq("flush_in_ready", 64'(in_ready), 64'd0);
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        check_eq("unexpected_output", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("result_val", 64'(result_val), 64'(e.res));
                        check_eq("result_addr", 64'(result_addr), 64'(e.addr));
                        check_eq("tag_out", 64'(tag_out), 64'(e.tag));
                        check_eq("branch_taken", 64'(branch_taken), 64'(e.taken));
                        check_eq("branch_target", 64'(branch_target), 64'(e.tgt));
                        check_eq("latency", 64'(cyc - e.acc_cyc), 64'(LAT + stalls - e.acc_st));
                    end
                end
                if (out_valid && !out_ready) stalls++;
                if (in_valid && in_ready) begin
                    e = model(alu_op, src1_val, src2_val, imm, alu_src, is_branch,
                              pc_in, dst_reg_addr, tag_in);
                    e.acc_cyc = cyc;
                    e.acc_st  = stalls;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic present(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] im, input logic src, input logic isbr,
                           input logic [31:0] pc, input logic [6:0] dst, input logic [4:0] tg);
        in_valid     = 1'b1;
        alu_op       = op;
        src1_val     = a;
        src2_val     = b;
        imm          = im;
        alu_src      = src;
        is_branch    = isbr;
        pc_in        = pc;
        dst_reg_addr = dst;
        tag_in       = tg;
    endtask

    task automatic wait_accept();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
        end
        check_eq("accept_timeout", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] im, input logic src, input logic isbr,
                           input logic [31:0] pc, input logic [6:0] dst, input logic [4:0] tg);
        present(op, a, b, im, src, isbr, pc, dst, tg);
        wait_accept();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before;
        reset_n = 1'b0;
        in_valid = 1'b0; src1_val = '0; src2_val = '0; imm = '0; alu_src = 1'b0;
        alu_op = '0; is_branch = 1'b0; pc_in = '0; dst_reg_addr = '0; tag_in = '0;
        flush = 1'b0; out_ready = 1'b1;
        idle(2);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_occupancy", 64'(occupancy), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_result", 64'(result_val), 64'd0);
        check_eq("rst_target", 64'(branch_target), 64'd0);
        @(posedge clk); #1;

        // back-to-back add/sub/xor, one result per cycle
        send_op(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 32'h0, 7'd10, 5'd1);
        send_op(ALU_SUB, 32'd20, 32'd6, 32'd0, 1'b0, 1'b0, 32'h0, 7'd11, 5'd2);
        present(ALU_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 1'b0, 32'h0, 7'd12, 5'd3);
        #3;
        check_eq("t2_out_valid", 64'(out_valid), 64'd1);
        check_eq("t2_add_result", 64'(result_val), 64'd12);
        check_eq("t2_add_tag", 64'(tag_out), 64'd1);
        wait_accept();
        idle(4);

        // backpressure with a full pipe
        out_ready = 1'b0;
        send_op(ALU_ADD, 32'd100, 32'd23, 32'd0, 1'b0, 1'b0, 32'h0, 7'd20, 5'd3);
        send_op(ALU_OR, 32'h10, 32'h01, 32'd0, 1'b0, 1'b0, 32'h0, 7'd21, 5'd4);
        present(ALU_AND, 32'hFF, 32'h0F, 32'd0, 1'b0, 1'b0, 32'h0, 7'd22, 5'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_result_stable", 64'(result_val), 64'd123);
            check_eq("bp_tag_stable", 64'(tag_out), 64'd3);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        idle(4);

        // flush with two ops in flight and a third presented
        out_ready = 1'b0;
        send_op(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 32'h0, 7'd30, 5'd6);
        send_op(ALU_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 32'h0, 7'd31, 5'd7);
        present(ALU_ADD, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0, 32'h0, 7'd32, 5'd8);
        flush = 1'b1;
        n_before = n_out;
        @(negedge clk);
        check_eq("fl_out_valid", 64'(out_valid), 64'd0);
        check_eq("fl_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check_eq("fl_occupancy_after", 64'(occupancy), 64'd0);
        idle(6);
        check_eq("fl_nothing_emerges", 64'(n_out), 64'(n_before));

        // reset with two ops in flight
        out_ready = 1'b0;
        send_op(ALU_SUB, 32'd9, 32'd1, 32'd0, 1'b0, 1'b0, 32'h0, 7'd40, 5'd9);
        send_op(ALU_SUB, 32'd8, 32'd1, 32'd0, 1'b0, 1'b0, 32'h0, 7'd41, 5'd10);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_occupancy", 64'(occupancy), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // branches
        send_op(ALU_BEQ, 32'd3, 32'd3, 32'h20, 1'b1, 1'b1, 32'h100, 7'd50, 5'd11);
        send_op(ALU_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 1'b1, 32'h100, 7'd51, 5'd12);
        send_op(ALU_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 1'b1, 32'h100, 7'd52, 5'd13);
        send_op(ALU_BNE, 32'd3, 32'd3, 32'h20, 1'b0, 1'b1, 32'h100, 7'd53, 5'd14);
        send_op(ALU_BGE, 32'd1, 32'hFFFF_FFFF, 32'h20, 1'b0, 1'b1, 32'h100, 7'd54, 5'd15);
        send_op(ALU_BGEU, 32'd1, 32'hFFFF_FFFF, 32'h20, 1'b0, 1'b1, 32'h100, 7'd55, 5'd16);
        send_op(ALU_BEQ, 32'd3, 32'd3, 32'h20, 1'b0, 1'b0, 32'h100, 7'd56, 5'd17);
        send_op(5'd21, 32'd3, 32'd3, 32'h20, 1'b0, 1'b1, 32'h100, 7'd57, 5'd18);

        // arithmetic edges
        send_op(ALU_SRA, 32'h8000_0000, 32'd0, 32'd31, 1'b1, 1'b0, 32'h0, 7'd60, 5'd19);
        send_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32'h0, 7'd61, 5'd20);
        send_op(ALU_SLL, 32'd3, 32'h21, 32'd0, 1'b0, 1'b0, 32'h0, 7'd62, 5'd21);
        send_op(ALU_BEQ, 32'd1, 32'd2, 32'h20, 1'b0, 1'b1, 32'hFFFF_FFFC, 7'd63, 5'd22);
        send_op(ALU_BNE, 32'd1, 32'd2, 32'h20, 1'b0, 1'b1, 32'hFFFF_FFF0, 7'd64, 5'd23);
        send_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32'h0, 7'd65, 5'd24);
        send_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32'h0, 7'd66, 5'd25);
        idle(4);

        // random ops under random backpressure
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    logic [31:0] ra;
                    logic [31:0] rb;
                    ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                    rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                    send_op(5'($urandom_range(0, 19)), ra, rb, $urandom, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), $urandom, 7'($urandom_range(0, 127)),
                            5'($urandom_range(0, 31)));
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(8);
        check_eq("drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
